// File: rtl/kernel_frame_ctrl_pkg.sv
// Shared token codes and register-map error bit indices for kernel_frame_ctrl
// and the blocks around it.
package kernel_frame_ctrl_pkg;

   localparam int DTYPE_WIDTH = 8;

   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h01;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h02;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 8'h03;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 8'h04;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 8'h40;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 8'h80;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'h80;

   localparam int KCTRL_ERR_OVERFLOW = 0;
   localparam int KCTRL_ERR_DIM      = 1;
   localparam int KCTRL_ERR_SYNC     = 2;

endpackage

// File: rtl/kernel_frame_ctrl_frame_dim_counter.sv
// Row/column counters for one frame: column saturation at MAX_COLS and the
// check of every row length against the first row of the frame.
module frame_dim_counter #(
   parameter int MAX_COLS       = 1288,
   parameter int NUM_COLS_WIDTH = $clog2(MAX_COLS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      row_start,
   input  logic                      row_end,
   input  logic                      pixel,
   output logic [NUM_COLS_WIDTH-1:0] ref_cols,
   output logic [15:0]               row_cnt,
   output logic                      overflow,
   output logic                      mismatch
);

   localparam logic [NUM_COLS_WIDTH-1:0] COL_LIMIT = NUM_COLS_WIDTH'(MAX_COLS);

   logic [NUM_COLS_WIDTH-1:0] col_cnt;

   assign overflow = pixel && (col_cnt == COL_LIMIT);
   // The first ROW_END of a frame defines the reference instead of being checked.
   assign mismatch = row_end && (row_cnt != 16'd0) && (col_cnt != ref_cols);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         col_cnt  <= '0;
         row_cnt  <= '0;
         ref_cols <= '0;
      end else begin
         if (row_start) begin
            col_cnt <= '0;
         end else if (pixel && !overflow) begin
            col_cnt <= col_cnt + 1'b1;
         end
         if (row_end) begin
            if (row_cnt != 16'hFFFF) begin
               row_cnt <= row_cnt + 16'd1;
            end
            if (row_cnt == 16'd0) begin
               ref_cols <= col_cnt;
            end
         end
      end
   end

endmodule

// File: rtl/kernel_frame_ctrl.sv
// Frame-synchronous front end of the kernel: one-cycle pixel pipeline, kernel
// enable that only changes at frame boundaries, frame status and sticky errors.
module kernel_frame_ctrl
   import kernel_frame_ctrl_pkg::*;
#(
   parameter int PIXEL_WIDTH    = 10,
   parameter int DATA_WIDTH     = 16,
   parameter int MAX_COLS       = 1288,
   parameter int NUM_COLS_WIDTH = $clog2(MAX_COLS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      dvi,
   input  logic [DTYPE_WIDTH-1:0]    dtypei,
   input  logic [PIXEL_WIDTH-1:0]    datai,
   input  logic [DATA_WIDTH-1:0]     meta_datai,
   input  logic                      enable_req,
   input  logic                      err_clear,
   output logic                      dvo,
   output logic [DTYPE_WIDTH-1:0]    dtypeo,
   output logic [PIXEL_WIDTH-1:0]    datao,
   output logic [DATA_WIDTH-1:0]     meta_datao,
   output logic                      kernel_enable,
   output logic                      enable_pending,
   output logic                      frame_done,
   output logic [15:0]               frame_count,
   output logic [15:0]               num_rows,
   output logic [NUM_COLS_WIDTH-1:0] num_cols,
   output logic [2:0]                err
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} state_t;

   state_t                    state;
   logic                      applied_en;
   logic                      in_frame;
   logic                      tok_fs, tok_fe, tok_rs, tok_re, tok_px;
   logic [2:0]                err_set;
   logic [NUM_COLS_WIDTH-1:0] ref_cols;
   logic [15:0]               row_cnt;
   logic                      overflow, mismatch;

   // NOTE: every signal driven here gets a value on every path, so no latch
   // can be inferred.
   always_comb begin
      in_frame = (state != IDLE);
      tok_fs   = dvi && (dtypei == DTYPE_FRAME_START);
      tok_fe   = dvi && (dtypei == DTYPE_FRAME_END);
      tok_rs   = dvi && (dtypei == DTYPE_ROW_START);
      tok_re   = dvi && (dtypei == DTYPE_ROW_END);
      tok_px   = dvi && ((dtypei & DTYPE_PIXEL_MASK) != '0);
      err_set                     = '0;
      err_set[KCTRL_ERR_OVERFLOW] = overflow;
      err_set[KCTRL_ERR_DIM]      = mismatch;
      err_set[KCTRL_ERR_SYNC]     = (tok_fs && in_frame) || (tok_fe && !in_frame);
   end

   assign enable_pending = (enable_req != applied_en);

   frame_dim_counter #(
      .MAX_COLS       (MAX_COLS),
      .NUM_COLS_WIDTH (NUM_COLS_WIDTH)
   ) u_dim (
      .clk       (clk),
      .reset     (reset),
      .clear     (tok_fs),
      .row_start (tok_rs && in_frame),
      .row_end   (tok_re && in_frame),
      .pixel     (tok_px && in_frame),
      .ref_cols  (ref_cols),
      .row_cnt   (row_cnt),
      .overflow  (overflow),
      .mismatch  (mismatch)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         applied_en    <= 1'b0;
         dvo           <= 1'b0;
         dtypeo        <= '0;
         datao         <= '0;
         meta_datao    <= '0;
         kernel_enable <= 1'b0;
         frame_done    <= 1'b0;
         frame_count   <= '0;
         num_rows      <= '0;
         num_cols      <= '0;
         err           <= '0;
      end else begin
         dvo        <= dvi;
         dtypeo     <= dtypei;
         datao      <= datai;
         meta_datao <= meta_datai;
         frame_done <= 1'b0;
         err        <= (err_clear ? 3'b000 : err) | err_set;

         // A FRAME_START always opens a fresh frame, even over an unfinished one.
         if (tok_fs) begin
            state         <= ACTIVE;
            applied_en    <= enable_req;
            kernel_enable <= enable_req;
         end else begin
            if (state == FAULT) begin
               kernel_enable <= 1'b0;
            end
            if (tok_fe && in_frame) begin
               state       <= IDLE;
               num_rows    <= row_cnt;
               num_cols    <= ref_cols;
               frame_count <= frame_count + 16'd1;
               frame_done  <= 1'b1;
            end else if (overflow) begin
               state <= FAULT;
            end
         end
      end
   end

endmodule

// File: tb/tb_kernel_frame_ctrl.sv
// Directed bench for kernel_frame_ctrl built with an 8-column limit.
module tb_kernel_frame_ctrl;
   import kernel_frame_ctrl_pkg::*;

   localparam logic [7:0] FS = DTYPE_FRAME_START;
   localparam logic [7:0] FE = DTYPE_FRAME_END;
   localparam logic [7:0] RS = DTYPE_ROW_START;
   localparam logic [7:0] RE = DTYPE_ROW_END;
   localparam logic [7:0] PX = DTYPE_PIXEL;
   localparam logic [7:0] HD = DTYPE_HEADER;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dvi = 1'b0;
   logic [7:0]  dtypei = '0;
   logic [9:0]  datai = '0;
   logic [15:0] meta_datai = '0;
   logic        enable_req = 1'b0;
   logic        err_clear = 1'b0;
   logic        dvo;
   logic [7:0]  dtypeo;
   logic [9:0]  datao;
   logic [15:0] meta_datao;
   logic        kernel_enable, enable_pending, frame_done;
   logic [15:0] frame_count, num_rows;
   logic [3:0]  num_cols;
   logic [2:0]  err;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   kernel_frame_ctrl #(
      .PIXEL_WIDTH (10),
      .DATA_WIDTH  (16),
      .MAX_COLS    (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .dvi            (dvi),
      .dtypei         (dtypei),
      .datai          (datai),
      .meta_datai     (meta_datai),
      .enable_req     (enable_req),
      .err_clear      (err_clear),
      .dvo            (dvo),
      .dtypeo         (dtypeo),
      .datao          (datao),
      .meta_datao     (meta_datao),
      .kernel_enable  (kernel_enable),
      .enable_pending (enable_pending),
      .frame_done     (frame_done),
      .frame_count    (frame_count),
      .num_rows       (num_rows),
      .num_cols       (num_cols),
      .err            (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one token mid-cycle, then sample just after the capturing edge.
   task automatic step(input logic dv, input logic [7:0] dt, input logic [9:0] d,
                       input logic en, input logic clr);
      @(negedge clk);
      dvi        = dv;
      dtypei     = dt;
      datai      = d;
      meta_datai = {d, 6'h2A};
      enable_req = en;
      err_clear  = clr;
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) done_cnt++;
   endtask

   task automatic send_row(input int n, input logic en);
      step(1'b1, RS, 10'd0, en, 1'b0);
      for (int i = 0; i < n; i++) step(1'b1, PX, 10'(i + 1), en, 1'b0);
      step(1'b1, RE, 10'd0, en, 1'b0);
   endtask

   typedef struct {
      logic       dv;
      logic [7:0] dt;
      logic [9:0] d;
      logic       en;
      logic       clr;
      logic       exp_ke;
      logic       exp_pend;
      logic       exp_done;
      int         exp_fc;
      int         exp_rows;
      int         exp_cols;
      logic [2:0] exp_err;
   } vec_t;

   vec_t vecs[15];

   initial begin
      //          dv  dt  d    en clr  ke pend done fc rows cols err
      vecs[0]  = '{1, FS, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000};
      vecs[1]  = '{1, RS, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000};
      vecs[2]  = '{1, PX, 10'h155, 1, 0, 0, 1, 0, 0, 0, 0, 3'b000};
      vecs[3]  = '{1, PX, 10'h2AA, 1, 0, 0, 1, 0, 0, 0, 0, 3'b000};
      vecs[4]  = '{1, RE, 10'h000, 1, 0, 0, 1, 0, 0, 0, 0, 3'b000};
      vecs[5]  = '{1, FE, 10'h000, 1, 0, 0, 1, 1, 1, 1, 2, 3'b000};
      vecs[6]  = '{0, PX, 10'h3FF, 1, 0, 0, 1, 0, 1, 1, 2, 3'b000};
      vecs[7]  = '{1, FS, 10'h000, 1, 0, 1, 0, 0, 1, 1, 2, 3'b000};
      vecs[8]  = '{1, RS, 10'h000, 1, 0, 1, 0, 0, 1, 1, 2, 3'b000};
      vecs[9]  = '{1, HD, 10'h123, 1, 0, 1, 0, 0, 1, 1, 2, 3'b000};
      vecs[10] = '{1, PX, 10'h001, 0, 0, 1, 1, 0, 1, 1, 2, 3'b000};
      vecs[11] = '{1, RE, 10'h000, 0, 0, 1, 1, 0, 1, 1, 2, 3'b000};
      vecs[12] = '{1, FE, 10'h000, 1, 0, 1, 0, 1, 2, 1, 1, 3'b000};
      vecs[13] = '{1, FE, 10'h000, 1, 0, 1, 0, 0, 2, 1, 1, 3'b100};
      vecs[14] = '{0, 8'h00, 10'h000, 1, 1, 1, 0, 0, 2, 1, 1, 3'b000};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_dvo", dvo, 0);
      check("rst_ke", kernel_enable, 0);
      check("rst_fc", frame_count, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b0;

      // Enable hand-over across frames, pass-through, stray FRAME_END.
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].dv, vecs[i].dt, vecs[i].d, vecs[i].en, vecs[i].clr);
         check($sformatf("v%0d_dvo", i), dvo, vecs[i].dv);
         check($sformatf("v%0d_dtype", i), dtypeo, vecs[i].dt);
         check($sformatf("v%0d_data", i), datao, vecs[i].d);
         check($sformatf("v%0d_meta", i), meta_datao, {vecs[i].d, 6'h2A});
         check($sformatf("v%0d_ke", i), kernel_enable, vecs[i].exp_ke);
         check($sformatf("v%0d_pend", i), enable_pending, vecs[i].exp_pend);
         check($sformatf("v%0d_done", i), frame_done, vecs[i].exp_done);
         check($sformatf("v%0d_fc", i), frame_count, vecs[i].exp_fc);
         check($sformatf("v%0d_rows", i), num_rows, vecs[i].exp_rows);
         check($sformatf("v%0d_cols", i), num_cols, vecs[i].exp_cols);
         check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      end

      // Reset mid-row discards the frame.
      step(1'b1, FS, 10'd0, 1'b1, 1'b0);
      step(1'b1, RS, 10'd0, 1'b1, 1'b0);
      step(1'b1, PX, 10'h3C3, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      dvi = 1'b1;
      dtypei = PX;
      datai = 10'h0F0;
      enable_req = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_dvo", dvo, 0);
      check("mid_rst_data", datao, 0);
      check("mid_rst_ke", kernel_enable, 0);
      check("mid_rst_pend", enable_pending, 0);
      check("mid_rst_fc", frame_count, 0);
      check("mid_rst_rows", num_rows, 0);
      check("mid_rst_cols", num_cols, 0);
      @(negedge clk);
      reset = 1'b0;
      dvi = 1'b0;

      // Normal 4 x 8 frame.
      done_cnt = 0;
      step(1'b1, FS, 10'd0, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) send_row(8, 1'b0);
      step(1'b1, FE, 10'd0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 10'd0, 1'b0, 1'b0);
      check("norm_done_cnt", done_cnt, 1);
      check("norm_fc", frame_count, 1);
      check("norm_rows", num_rows, 4);
      check("norm_cols", num_cols, 8);
      check("norm_err", err, 0);

      // Overflow: 9-pixel row against an 8-column limit.
      step(1'b1, FS, 10'd0, 1'b1, 1'b0);
      check("ovf_fs_ke", kernel_enable, 1);
      step(1'b1, RS, 10'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, PX, 10'(i), 1'b1, 1'b0);
      check("ovf_px8_err", err, 3'b000);
      step(1'b1, PX, 10'd8, 1'b1, 1'b0);
      check("ovf_px9_err", err, 3'b001);
      check("ovf_px9_ke", kernel_enable, 1);
      step(1'b1, RE, 10'd0, 1'b1, 1'b0);
      check("ovf_next_ke", kernel_enable, 0);
      step(1'b1, FE, 10'd0, 1'b1, 1'b0);
      check("ovf_fe_ke", kernel_enable, 0);
      check("ovf_fe_fc", frame_count, 2);
      step(1'b0, 8'h00, 10'd0, 1'b1, 1'b1);
      check("ovf_idle_ke", kernel_enable, 0);
      check("ovf_clr_err", err, 3'b000);
      step(1'b1, FS, 10'd0, 1'b1, 1'b0);
      check("ovf_restore_ke", kernel_enable, 1);

      // err_clear in the same cycle as an overflow: set wins.
      step(1'b1, RS, 10'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, PX, 10'(i), 1'b1, 1'b0);
      step(1'b1, PX, 10'd8, 1'b1, 1'b1);
      check("clr_vs_ovf_err", err, 3'b001);
      step(1'b1, FE, 10'd0, 1'b1, 1'b0);
      check("clr_vs_ovf_fc", frame_count, 3);

      // Row-length mismatch: 8, 8, 7.
      step(1'b0, 8'h00, 10'd0, 1'b0, 1'b1);
      step(1'b1, FS, 10'd0, 1'b0, 1'b0);
      send_row(8, 1'b0);
      send_row(8, 1'b0);
      check("dim_pre_err", err, 3'b000);
      send_row(7, 1'b0);
      check("dim_err", err, 3'b010);
      step(1'b1, FE, 10'd0, 1'b0, 1'b0);
      check("dim_cols", num_cols, 8);
      check("dim_rows", num_rows, 3);
      check("dim_fc", frame_count, 4);

      // Two FRAME_STARTs without FRAME_END.
      step(1'b0, 8'h00, 10'd0, 1'b0, 1'b1);
      check("sync_pre_err", err, 3'b000);
      step(1'b1, FS, 10'd0, 1'b0, 1'b0);
      send_row(3, 1'b0);
      step(1'b1, FS, 10'd0, 1'b0, 1'b0);
      check("sync_err", err, 3'b100);
      check("sync_fc", frame_count, 4);
      check("sync_done", frame_done, 0);
      step(1'b1, FE, 10'd0, 1'b0, 1'b0);
      check("sync_fe_fc", frame_count, 5);
      check("sync_fe_rows", num_rows, 0);
      step(1'b0, 8'h00, 10'd0, 1'b0, 1'b1);
      check("sync_clr_err", err, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
